// File: rtl/sva_dffen_mon.sv
// sva_dffen_mon: monitor for one W-bit enabled flop (en, d, q).
// Keeps a shadow model of the expected q. Flags unknown enables, unknown
// data on enabled writes, and q/model mismatches. Counts enabled writes and
// failing cycles with saturating counters. This is testbench-only and is
// not meant for synthesis into the design.
// Optional macro SVA_DFFEN_MON_ASSERT_EN adds one named deferred assertion
// per check. Register behaviour does not depend on the macro.
module sva_dffen_mon #(
    parameter int           W         = 1,
    parameter bit           HAS_RESET = 1'b1,
    parameter logic [W-1:0] RESET_VAL = 'b0,
    parameter bit           CHECK_D_X = 1'b1,
    parameter int           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     d,
    input  logic [W-1:0]     q,
    output logic [W-1:0]     model_q,
    output logic             model_vld,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] upd_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        UNINIT = 2'd0,
        ACTIVE = 2'd1,
        FAILED = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [W-1:0]       shadow_q, shadow_d;
    logic               vld_q,    vld_d;
    logic               err_q,    err_d;
    logic [2:0]         code_q,   code_d;
    logic [CNT_W-1:0]   upd_q,    upd_d;
    logic [CNT_W-1:0]   ecnt_q,   ecnt_d;

    logic run;    // FSM past its first reset
    logic live;   // checks armed this cycle
    logic c0, c1, c2, fail;

    // Check terms. The 4-state operators are deliberate: an unknown q
    // against a known model counts as a mismatch.
    always_comb begin
        run  = (state_q == ACTIVE) || (state_q == FAILED);
        live = run && !rst;
        c0   = live && $isunknown(en);
        c1   = live && CHECK_D_X && (en === 1'b1) && $isunknown(d);
        c2   = live && vld_q && (q !== shadow_q);
        fail = c0 | c1 | c2;
    end

    // Next-state logic: model update, counters, and the first-failure capture.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        vld_d    = vld_q;
        err_d    = err_q;
        code_d   = code_q;
        upd_d    = upd_q;
        ecnt_d   = ecnt_q;
        if (run) begin
            if (en === 1'b1) begin
                shadow_d = d;
                vld_d    = 1'b1;
                if (upd_q != {CNT_W{1'b1}}) upd_d = upd_q + CNT_W'(1);
            end else if (en !== 1'b0) begin
                // An unknown enable leaves the real flop indeterminate.
                vld_d = 1'b0;
            end
            if (fail) begin
                state_d = FAILED;
                if (ecnt_q != {CNT_W{1'b1}}) ecnt_d = ecnt_q + CNT_W'(1);
                if (!err_q) begin
                    err_d  = 1'b1;
                    code_d = {c2, c1, c0};
                end
            end
        end
    end

    // State registers. The synchronous reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACTIVE;
            shadow_q <= RESET_VAL;
            vld_q    <= HAS_RESET;
            err_q    <= 1'b0;
            code_q   <= 3'b000;
            upd_q    <= '0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            code_q   <= code_d;
            upd_q    <= upd_d;
            ecnt_q   <= ecnt_d;
        end
    end

    // Before the first reset the registers are meaningless, so the outputs
    // show reset values. An unknown state also falls into the else branch.
    always_comb begin
        if (run) begin
            model_q   = shadow_q;
            model_vld = vld_q;
            err       = err_q;
            err_code  = code_q;
            upd_cnt   = upd_q;
            err_cnt   = ecnt_q;
        end else begin
            model_q   = RESET_VAL;
            model_vld = HAS_RESET;
            err       = 1'b0;
            err_code  = 3'b000;
            upd_cnt   = '0;
            err_cnt   = '0;
        end
    end

`ifdef SVA_DFFEN_MON_ASSERT_EN
    // One deferred assertion per check term. These fire on every failing cycle.
    always_comb begin
        if (live) begin
            a_en_known: assert final (!$isunknown(en))
                else $error("%m: enable unknown, en=%b", en);
            a_d_known: assert final (!(CHECK_D_X && (en === 1'b1) && $isunknown(d)))
                else $error("%m: data unknown on enabled write, d=%h", d);
            a_q_match: assert final (!(vld_q && (q !== shadow_q)))
                else $error("%m: q=%h differs from model %h", q, shadow_q);
        end
    end
`endif

endmodule

// File: tb/tb_sva_dffen_mon.sv
// Directed bench for sva_dffen_mon. It uses three instances:
//   u_a: W=8, RESET_VAL=8'h5A (main flow, failures, mid-run reset)
//   u_b: W=8, HAS_RESET=0 (model invalid until the first write)
//   u_c: W=8, CNT_W=2 (saturating update counter)
// X-driven vectors adapt their expected values when the simulator is 2-state.
module tb_sva_dffen_mon;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       en_a, en_b, en_c;
    logic [7:0] d_a, q_a, d_b, q_b, d_c, q_c;

    logic [7:0] mq_a, mq_b, mq_c;
    logic       mv_a, mv_b, mv_c;
    logic       er_a, er_b, er_c;
    logic [2:0] ec_a, ec_b, ec_c;
    logic [15:0] uc_a, ecn_a, uc_b, ecn_b;
    logic [1:0]  uc_c, ecn_c;

    sva_dffen_mon #(.W(8), .HAS_RESET(1'b1), .RESET_VAL(8'h5A), .CHECK_D_X(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .d(d_a), .q(q_a),
        .model_q(mq_a), .model_vld(mv_a), .err(er_a), .err_code(ec_a),
        .upd_cnt(uc_a), .err_cnt(ecn_a));

    sva_dffen_mon #(.W(8), .HAS_RESET(1'b0), .RESET_VAL(8'h00), .CHECK_D_X(1'b1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .d(d_b), .q(q_b),
        .model_q(mq_b), .model_vld(mv_b), .err(er_b), .err_code(ec_b),
        .upd_cnt(uc_b), .err_cnt(ecn_b));

    sva_dffen_mon #(.W(8), .HAS_RESET(1'b1), .RESET_VAL(8'h00), .CHECK_D_X(1'b1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .d(d_c), .q(q_c),
        .model_q(mq_c), .model_vld(mv_c), .err(er_c), .err_code(ec_c),
        .upd_cnt(uc_c), .err_cnt(ecn_c));

    int n_vec = 0;
    int n_err = 0;
    logic       xbit  = 1'bx;
    logic [7:0] xbyte = 8'hxx;
    bit four_state;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        four_state = $isunknown(xbit);
        rst = 1'b1;
        en_a = 1'b0; d_a = 8'h00; q_a = 8'h5A;
        en_b = 1'b0; d_b = 8'h00; q_b = 8'h00;
        en_c = 1'b0; d_c = 8'h00; q_c = 8'h00;

        // Reset for two cycles.
        tick(2);
        chk("a_rst_err",    {31'd0, er_a}, 32'd0);
        chk("a_rst_code",   {29'd0, ec_a}, 32'd0);
        chk("a_rst_upd",    {16'd0, uc_a}, 32'd0);
        chk("a_rst_model",  {24'd0, mq_a}, 32'h5A);
        chk("a_rst_vld",    {31'd0, mv_a}, 32'd1);

        // Ten idle cycles with q holding the reset value.
        rst = 1'b0;
        tick(10);
        chk("a_idle_err",   {31'd0, er_a}, 32'd0);
        chk("a_idle_upd",   {16'd0, uc_a}, 32'd0);
        chk("a_idle_model", {24'd0, mq_a}, 32'h5A);

        // Three writes, with q following one cycle behind.
        en_a = 1'b1; d_a = 8'h11; q_a = 8'h5A; tick();
        d_a = 8'h22; q_a = 8'h11; tick();
        d_a = 8'h33; q_a = 8'h22; tick();
        en_a = 1'b0; q_a = 8'h33; tick();
        chk("a_wr_err",     {31'd0, er_a}, 32'd0);
        chk("a_wr_upd",     {16'd0, uc_a}, 32'd3);
        chk("a_wr_model",   {24'd0, mq_a}, 32'h33);

        // Unknown enable together with a q mismatch (model 33, q 00).
        en_a = four_state ? xbit : 1'b0; q_a = 8'h00; tick();
        chk("a_f1_err",     {31'd0, er_a}, 32'd1);
        chk("a_f1_code",    {29'd0, ec_a}, four_state ? 32'd5 : 32'd4);
        chk("a_f1_cnt",     {16'd0, ecn_a}, 32'd1);

        // A later enabled write of unknown data: the code stays frozen, the count rises.
        en_a = 1'b1; d_a = xbyte; q_a = 8'h00; tick();
        chk("a_f2_code",    {29'd0, ec_a}, four_state ? 32'd5 : 32'd4);
        chk("a_f2_cnt",     {16'd0, ecn_a}, 32'd2);
        chk("a_f2_upd",     {16'd0, uc_a}, 32'd4);

        // Reset while FAILED, with a simultaneous write of FF. Reset must win.
        rst = 1'b1; en_a = 1'b1; d_a = 8'hFF; tick();
        chk("a_mr_err",     {31'd0, er_a}, 32'd0);
        chk("a_mr_code",    {29'd0, ec_a}, 32'd0);
        chk("a_mr_cnt",     {16'd0, ecn_a}, 32'd0);
        chk("a_mr_upd",     {16'd0, uc_a}, 32'd0);
        chk("a_mr_model",   {24'd0, mq_a}, 32'h5A);
        chk("a_mr_vld",     {31'd0, mv_a}, 32'd1);

        // Checks must be armed again (ACTIVE): q 00 against model 5A fails.
        rst = 1'b0; en_a = 1'b0; q_a = 8'h00; tick();
        chk("a_act_err",    {31'd0, er_a}, 32'd1);
        chk("a_act_code",   {29'd0, ec_a}, 32'd4);
        chk("a_act_cnt",    {16'd0, ecn_a}, 32'd1);

        // Fresh reset for the HAS_RESET=0 and CNT_W=2 instances.
        rst = 1'b1; q_a = 8'h5A; tick();
        chk("b_rst_vld",    {31'd0, mv_b}, 32'd0);
        chk("b_rst_err",    {31'd0, er_b}, 32'd0);

        // Unknown q before the first write must not be flagged.
        rst = 1'b0; en_b = 1'b0; q_b = xbyte; tick(3);
        chk("b_pre_err",    {31'd0, er_b}, 32'd0);
        chk("b_pre_cnt",    {16'd0, ecn_b}, 32'd0);

        en_b = 1'b1; d_b = 8'h42; tick();
        chk("b_wr_vld",     {31'd0, mv_b}, 32'd1);
        chk("b_wr_model",   {24'd0, mq_b}, 32'h42);
        chk("b_wr_upd",     {16'd0, uc_b}, 32'd1);

        en_b = 1'b0; q_b = 8'h42; tick(2);
        chk("b_post_err",   {31'd0, er_b}, 32'd0);
        chk("b_post_code",  {29'd0, ec_b}, 32'd0);

        // Five writes into a 2-bit counter.
        for (int i = 1; i <= 5; i++) begin
            en_c = 1'b1; d_c = 8'(i); q_c = 8'(i - 1); tick();
            if (i == 3) chk("c_upd3", {30'd0, uc_c}, 32'd3);
        end
        en_c = 1'b0; q_c = 8'h05; tick();
        chk("c_upd_sat",    {30'd0, uc_c}, 32'd3);
        chk("c_model",      {24'd0, mq_c}, 32'h05);
        chk("c_vld",        {31'd0, mv_c}, 32'd1);
        chk("c_err",        {31'd0, er_c}, 32'd0);
        chk("c_code",       {29'd0, ec_c}, 32'd0);
        chk("c_ecnt",       {30'd0, ecn_c}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
